// File: rtl/pulse_fifo_reader_if.sv
// rtl/pulse_fifo_reader_if.sv - FIFO read port and Avalon-MM slave bundle for pulse_fifo_reader
interface pulse_fifo_reader_if #(
  parameter int USEDW_W = 8
);
  logic [63:0]        fifo_q;
  logic               fifo_empty;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_rdreq;
  logic [1:0]         avs_address;
  logic               avs_read;
  logic               avs_write;
  logic [31:0]        avs_writedata;
  logic [31:0]        avs_readdata;
  logic               irq;

  modport slave (
    input  fifo_q, fifo_empty, fifo_usedw,
    input  avs_address, avs_read, avs_write, avs_writedata,
    output fifo_rdreq, avs_readdata, irq
  );

  modport master (
    output fifo_q, fifo_empty, fifo_usedw,
    output avs_address, avs_read, avs_write, avs_writedata,
    input  fifo_rdreq, avs_readdata, irq
  );
endinterface

// File: rtl/pulse_fifo_reader.sv
// rtl/pulse_fifo_reader.sv - drains a 64-bit photon-count FIFO into a holding register read as two 32-bit halves
module pulse_fifo_reader #(
  parameter int USEDW_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pulse_fifo_reader_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] A_DATA_LO = 2'd0;
  localparam logic [1:0] A_DATA_HI = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [1:0] A_CONTROL = 2'd3;

  state_t      r_state;
  logic [63:0] r_hold;
  logic        r_valid;
  logic        r_underrun;
  logic        r_irq_en;
  logic        r_irq;
  logic [15:0] r_words_read;
  logic [31:0] r_readdata;

  logic        w_rd_access;
  logic        w_wr_access;
  logic        w_ctrl_write;
  logic        w_hi_read;
  logic        w_flush;
  logic        w_pop;
  logic        w_underrun_evt;
  logic        w_clr_underrun;
  logic        w_rdreq;
  logic [7:0]  w_usedw_ext;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  // A read in the same cycle as a write wins; the write is simply dropped.
  always_comb begin
    w_rd_access    = bus.avs_read;
    w_wr_access    = bus.avs_write & ~bus.avs_read;
    w_ctrl_write   = w_wr_access & (bus.avs_address == A_CONTROL);
    w_hi_read      = w_rd_access & (bus.avs_address == A_DATA_HI);
    w_flush        = w_ctrl_write & bus.avs_writedata[2];
    w_pop          = w_hi_read & r_valid & ~w_flush;
    w_underrun_evt = w_hi_read & ~r_valid;
    w_clr_underrun = w_ctrl_write & bus.avs_writedata[1];
    w_rdreq        = reset_n & ~bus.fifo_empty &
                     ((r_state == ST_IDLE) | (r_state == ST_FLUSH));
  end

  always_comb begin
    w_usedw_ext = '0;
    w_usedw_ext[USEDW_W-1:0] = bus.fifo_usedw;
  end

  // Register reads see the state before this edge's update.
  always_comb begin
    w_rdata = '0;
    case (bus.avs_address)
      A_DATA_LO: w_rdata = r_hold[31:0];
      A_DATA_HI: w_rdata = r_valid ? r_hold[63:32] : 32'd0;
      A_STATUS:  w_rdata = {r_words_read, w_usedw_ext, 6'd0, r_underrun, r_valid};
      A_CONTROL: w_rdata = {30'd0, (r_state == ST_FLUSH), r_irq_en};
      default:   w_rdata = '0;
    endcase
  end

  assign w_unused_wdata = ^bus.avs_writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_valid      <= 1'b0;
      r_underrun   <= 1'b0;
      r_irq_en     <= 1'b0;
      r_irq        <= 1'b0;
      r_words_read <= '0;
      r_readdata   <= '0;
    end else begin
      if (w_rd_access) begin
        r_readdata <= w_rdata;
      end

      // A new underrun outranks a clear landing on the same edge.
      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
      end else if (w_clr_underrun) begin
        r_underrun <= 1'b0;
      end

      if (w_ctrl_write) begin
        r_irq_en <= bus.avs_writedata[0];
      end

      if (w_pop) begin
        r_words_read <= r_words_read + 16'd1;
      end

      r_irq <= r_irq_en & r_valid;

      if (w_flush) begin
        r_state <= ST_FLUSH;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rdreq) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            r_hold  <= bus.fifo_q;
            r_valid <= 1'b1;
            r_state <= ST_FULL;
          end
          ST_FULL: begin
            if (w_pop) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          ST_FLUSH: begin
            // Words fetched while draining are never captured.
            if (bus.fifo_empty) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_rdreq   = w_rdreq;
  assign bus.avs_readdata = r_readdata;
  assign bus.irq          = r_irq;

endmodule

// File: tb/tb_pulse_fifo_reader.sv
// tb/tb_pulse_fifo_reader.sv - randomized bench for pulse_fifo_reader against a word-queue model
module tb_pulse_fifo_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #10 clk = ~clk;

  pulse_fifo_reader_if #(.USEDW_W(8)) bus ();

  pulse_fifo_reader #(.USEDW_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] fq[$];
  logic [63:0] exp_q[$];
  logic [15:0] exp_words = 16'd0;
  int          rd_total = 0;
  int          rd_run = 0;
  int          rd_max = 0;
  int          rd_empty_viol = 0;

  task automatic fifo_sync();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_usedw = 8'(fq.size());
  endtask

  task automatic push(input logic [63:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_sync();
  endtask

  // One clock: starts and ends at a falling edge; the FIFO model answers rdreq one cycle late.
  task automatic cycle();
    logic rd;
    #1;
    rd = bus.fifo_rdreq;
    if (rd) begin
      rd_total++;
      rd_run++;
      if (rd_run > rd_max) rd_max = rd_run;
      if (bus.fifo_empty) rd_empty_viol++;
    end else begin
      rd_run = 0;
    end
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) bus.fifo_q = fq.pop_front();
    fifo_sync();
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    cycle();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    bus.avs_address = a;
    bus.avs_writedata = v;
    bus.avs_write = 1'b1;
    cycle();
    bus.avs_write = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    logic [31:0] s;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      bus_read(2'd2, s);
      seen = s[0];
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: got valid %b expected 1", tag, seen);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] lo, hi;
    logic [63:0] w;
    bus_read(2'd0, lo);
    bus_read(2'd1, hi);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    exp_words = exp_words + 16'd1;
    vectors++;
    if ({hi, lo} !== w) begin
      miscompares++;
      $display("FAIL %s_word: got %h expected %h", tag, {hi, lo}, w);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({bus.fifo_rdreq, bus.avs_readdata, bus.irq} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdreq %b rdata %h irq %b expected 0 0 0",
               bus.fifo_rdreq, bus.avs_readdata, bus.irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_status: got %h expected 00000000", d);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_control: got %h expected 00000000", d);
    end
  endtask

  task automatic test_prefetch();
    logic [31:0] d;
    int          rd0;
    rd0 = rd_total;
    push(64'h1122334455667788);
    #1;
    vectors++;
    if (bus.fifo_rdreq !== 1'b1) begin
      miscompares++;
      $display("FAIL prefetch_rdreq: got %b expected 1", bus.fifo_rdreq);
    end
    cycle();
    cycle();
    vectors++;
    if (rd_total - rd0 !== 1) begin
      miscompares++;
      $display("FAIL prefetch_rdreq_cycles: got %0d expected 1", rd_total - rd0);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL prefetch_valid: got %b expected 1", d[0]);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h55667788) begin
      miscompares++;
      $display("FAIL prefetch_lo: got %h expected 55667788", d);
    end
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'h11223344) begin
      miscompares++;
      $display("FAIL prefetch_hi: got %h expected 11223344", d);
    end
    void'(exp_q.pop_front());
    exp_words = exp_words + 16'd1;
    bus_read(2'd2, d);
    vectors++;
    if (d[31:16] !== 16'd1 || d[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL prefetch_count: got %h expected 0001 valid 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    rd_empty_viol = 0;
    for (int i = 0; i < 4; i++) push({$urandom(), $urandom()});
    for (int i = 0; i < 4; i++) begin
      wait_valid("drain");
      pop_check("drain");
      repeat ($urandom_range(0, 3)) cycle();
    end
    bus_read(2'd2, d);
    vectors++;
    if (d[31:16] !== exp_words) begin
      miscompares++;
      $display("FAIL drain_count: got %h expected %h", d[31:16], exp_words);
    end
    vectors++;
    if (rd_empty_viol !== 0) begin
      miscompares++;
      $display("FAIL drain_rdreq_empty: got %0d expected 0", rd_empty_viol);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d;
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL underrun_data: got %h expected 00000000", d);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_flag: got %b expected 1", d[1]);
    end
    // read and clear-write together: read served, clear dropped
    bus.avs_writedata = 32'h2;
    bus.avs_write = 1'b1;
    bus_read(2'd3, d);
    bus_read(2'd1, d);
    bus.avs_write = 1'b0;
    bus_read(2'd2, d);
    vectors++;
    if (d[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_sticky: got %b expected 1", d[1]);
    end
    bus_write(2'd3, 32'h2);
    bus_read(2'd2, d);
    vectors++;
    if (d[1] !== 1'b0 || d[31:16] !== exp_words) begin
      miscompares++;
      $display("FAIL underrun_clear: got flag %b count %h expected 0 %h", d[1], d[31:16], exp_words);
    end
  endtask

  task automatic test_wait_cases();
    logic [31:0] d;
    push({$urandom(), $urandom()});
    cycle();
    bus_read(2'd1, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL wait_hi_read: got %h expected 00000000", d);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d[1] !== 1'b1 || d[31:16] !== exp_words) begin
      miscompares++;
      $display("FAIL wait_underrun: got flag %b count %h expected 1 %h", d[1], d[31:16], exp_words);
    end
    pop_check("wait_word");
    bus_write(2'd3, 32'h2);
    push({$urandom(), $urandom()});
    cycle();
    bus_write(2'd3, 32'h4);
    exp_q.delete();
    repeat (3) cycle();
    push({$urandom(), $urandom()});
    wait_valid("after_wait_flush");
    pop_check("after_wait_flush");
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int          rd0;
    push({$urandom(), $urandom()});
    wait_valid("flush_pre");
    for (int i = 0; i < 5; i++) push({$urandom(), $urandom()});
    rd0 = rd_total;
    rd_max = 0;
    bus_write(2'd3, 32'h4);
    exp_q.delete();
    bus_read(2'd2, d);
    vectors++;
    if (d[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got %b expected 0", d[0]);
    end
    repeat (8) cycle();
    vectors++;
    if (rd_total - rd0 !== 5 || rd_max !== 5) begin
      miscompares++;
      $display("FAIL flush_rdreq: got %0d total %0d run expected 5 5", rd_total - rd0, rd_max);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_idle: got %h expected 00000000", d);
    end
    bus_read(2'd2, d);
    vectors++;
    if (d[31:16] !== exp_words || d[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_count: got %h expected %h valid 0", d[31:16], exp_words);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    push({$urandom(), $urandom()});
    wait_valid("irq");
    repeat (2) cycle();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_disabled: got %b expected 0", bus.irq);
    end
    bus_write(2'd3, 32'h1);
    cycle();
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_enabled: got %b expected 1", bus.irq);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL irq_ctrl: got %h expected 00000001", d);
    end
    pop_check("irq");
    cycle();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_after_pop: got %b expected 0", bus.irq);
    end
    bus_write(2'd3, 32'h0);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    push({$urandom(), $urandom()});
    wait_valid("wrap");
    force dut.r_words_read = 16'hFFFF;
    #1;
    release dut.r_words_read;
    exp_words = 16'hFFFF;
    pop_check("wrap");
    bus_read(2'd2, d);
    vectors++;
    if (d[31:16] !== 16'h0000 || d[31:16] !== exp_words) begin
      miscompares++;
      $display("FAIL wrap_count: got %h expected 0000", d[31:16]);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d);
    push({$urandom(), $urandom()});
    push({$urandom(), $urandom()});
    cycle();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.fifo_rdreq, bus.avs_readdata, bus.irq} !== 34'd0) begin
      miscompares++;
      $display("FAIL midop_reset: got rdreq %b rdata %h irq %b expected 0 0 0",
               bus.fifo_rdreq, bus.avs_readdata, bus.irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    void'(exp_q.pop_front());
    exp_words = 16'd0;
    bus_read(2'd2, d);
    vectors++;
    if (d[31:16] !== exp_words || d[1:0] !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_status: got %h expected count %h flags 0", d, exp_words);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL midop_control: got %h expected 00000000", d);
    end
    wait_valid("midop");
    pop_check("midop");
  endtask

  initial begin
    #(50000 * 20);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.avs_address = 2'd0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = 32'd0;
    bus.fifo_q = 64'd0;
    fifo_sync();
    test_reset();
    test_prefetch();
    test_back_to_back();
    test_underrun();
    test_wait_cases();
    test_flush();
    test_irq();
    test_wrap();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_fifo_reader.md
# pulse_fifo_reader

Reader end of the 64-bit photon-count FIFO that the pulse-counter path fills. The block drains the FIFO one word at a time into a holding register and presents each word to the HPS as two 32-bit halves over an Avalon-MM slave. It also provides status, an underrun flag, a flush command and an interrupt. It sits between the FIFO read port and the lightweight HPS-to-FPGA bridge.

## Interface
Parameters:
- USEDW_W, 8: width of the FIFO fill-level input. Must be ≤ 8.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- fifo_q  in  64  FIFO read data. Normal (non-show-ahead) mode: valid the cycle after fifo_rdreq.
- fifo_empty  in  1  FIFO empty flag.
- fifo_usedw  in  USEDW_W  FIFO fill level.
- fifo_rdreq  out  1  FIFO read request.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data. Registered; fixed read latency of 1.
- irq  out  1  level interrupt.

## Operation
- Holding register: hold[63:0] plus a valid flag.
- State machine states:
  - IDLE: holding register empty.
  - WAIT: read issued, data arrives this cycle.
  - FULL: holding register valid.
  - FLUSH: draining the FIFO.
- fifo_rdreq is combinational:
  - (IDLE & !fifo_empty) or (FLUSH & !fifo_empty).
  - Never asserted while fifo_empty = 1.
- State transitions:
  - IDLE → WAIT on rdreq.
  - WAIT → FULL: capture hold <= fifo_q and set valid.
  - FULL → IDLE on a successful pop.
- Register map (avs_address):
  - 0 DATA_LO: returns hold[31:0]. No side effect.
  - 1 DATA_HI: returns hold[63:32]. If valid: pop (clear valid) and increment the words_read counter. If not valid: returns 0 and sets the sticky underrun flag.
  - 2 STATUS: bit0 valid; bit1 underrun; bits[15:8] fifo_usedw, zero-extended; bits[31:16] words_read.
  - 3 CONTROL:
    - Write bit0 sets irq_en.
    - Write bit1 = 1 clears underrun.
    - Write bit2 = 1 starts a flush.
    - Read returns {30'b0, busy_flush, irq_en}.
- Flush behaviour:
  - Any state → FLUSH; valid is cleared immediately.
  - In FLUSH, rdreq is asserted every cycle while !fifo_empty; returned data is discarded.
  - FLUSH → IDLE in the first cycle fifo_empty = 1.
  - A read still pending from WAIT is discarded.
- words_read: 16-bit counter, wraps 0xFFFF → 0x0000, cleared only by reset.
- irq = irq_en & valid, registered.
- Simultaneous events:
  - avs_read and avs_write in the same cycle: the read is served and the write is dropped.
  - Flush write during a pop: flush wins and the counter does not increment.
  - DATA_HI read during WAIT: the read sees valid = 0, so it is an underrun and no pop occurs.
  - Clearing underrun in the same cycle as a new underrun event: the flag stays set.
- Reset mid-operation: all state is cleared. A word already popped from the FIFO in WAIT is lost, and this loss is accepted.

## Timing
- Reset values:
  - fifo_rdreq 0, avs_readdata 0, irq 0.
  - valid 0, underrun 0, irq_en 0, words_read 0, state IDLE.
- Prefetch latency:
  - rdreq asserts in cycle N (IDLE, !fifo_empty).
  - WAIT is cycle N+1, where fifo_q is captured.
  - valid = 1 from cycle N+2.
  - irq = 1 from cycle N+3.
- After a pop in cycle M:
  - State is IDLE in cycle M+1.
  - The next rdreq is in M+1 if the FIFO is non-empty.
  - The next word is valid in M+3.
- Throughput: one word per 3 cycles. Peak is limited by the HPS bus, not by this block.
- avs_readdata is updated on the clock edge after avs_read and holds its value until the next read.
- Register reads sample state as it stands before the same-edge update. In particular, STATUS read in the same cycle as a pop reports the pre-pop valid flag.

## Test plan
- Prefetch: reset, then present fifo_empty = 0 with fifo_q = 0x1122334455667788 → rdreq high exactly 1 cycle; STATUS bit0 = 1 two cycles later; DATA_LO reads 0x55667788; DATA_HI reads 0x11223344; STATUS bits[31:16] = 1.
- Back-to-back drain: preload 4 words with the FIFO model non-empty → 4 LO/HI pairs return the words in order; rdreq never asserts while fifo_empty = 1; words_read = 4.
- Underrun: DATA_HI read with valid = 0 → readdata 0 and STATUS bit1 = 1. CONTROL write 0x2 → bit1 = 0. Simultaneous clear and new underrun → bit1 stays 1.
- Flush: valid = 1 with 5 words in the FIFO, write CONTROL 0x4 → valid = 0 next cycle; rdreq asserted for 5 consecutive cycles; state returns to IDLE; words_read unchanged.
- Interrupt: irq_en = 0 with a word valid → irq = 0. Write CONTROL 0x1 → irq = 1 one cycle later. Pop → irq = 0 within 1 cycle.
- Wrap and reset: force words_read to 0xFFFF, then pop → 0x0000. Assert reset_n low during WAIT → all outputs 0 immediately, with no clock edge required.
